// File: rtl/cache_line_fill_pkg.sv
// cache_line_fill_pkg: shared state enum, bus width and line geometry helpers for the line-fill engine
package cache_fill_pkg;
  localparam int BUS_W = 32;
  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_e;
  function automatic int words_of(input int dw);
    return dw / BUS_W;
  endfunction
  function automatic int ofs_of(input int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/cache_line_fill_if.sv
// cache_line_fill_if: fill request, Wishbone read master and line-RAM write port of the fill engine
interface cache_line_fill_if #(parameter int DATA_WIDTH = 128, parameter int ADDRESS_WIDTH = 7);
  logic                     i_fill_req;
  logic [31:0]              i_fill_addr;
  logic                     o_fill_busy;
  logic                     o_fill_done;
  logic                     o_fill_err;
  logic                     o_crit_valid;
  logic [31:0]              o_crit_data;
  logic [31:0]              o_wb_adr;
  logic                     o_wb_cyc;
  logic                     o_wb_stb;
  logic [3:0]               o_wb_sel;
  logic [31:0]              i_wb_dat;
  logic                     i_wb_ack;
  logic                     i_wb_err;
  logic [ADDRESS_WIDTH-1:0] o_ram_address;
  logic [DATA_WIDTH-1:0]    o_ram_write_data;
  logic                     o_ram_write_enable;
  modport master (
    input  i_fill_req, i_fill_addr, i_wb_dat, i_wb_ack, i_wb_err,
    output o_fill_busy, o_fill_done, o_fill_err, o_crit_valid, o_crit_data,
           o_wb_adr, o_wb_cyc, o_wb_stb, o_wb_sel,
           o_ram_address, o_ram_write_data, o_ram_write_enable
  );
  modport slave (
    output i_fill_req, i_fill_addr, i_wb_dat, i_wb_ack, i_wb_err,
    input  o_fill_busy, o_fill_done, o_fill_err, o_crit_valid, o_crit_data,
           o_wb_adr, o_wb_cyc, o_wb_stb, o_wb_sel,
           o_ram_address, o_ram_write_data, o_ram_write_enable
  );
endinterface

// File: rtl/cache_line_fill_assembler.sv
// cache_line_assembler: lane-addressed beat register building one cache line, cleared at fill start
module cache_line_assembler import cache_fill_pkg::*; #(
  parameter int DATA_WIDTH = 128,
  parameter int IW = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  we_i,
  input  logic [IW-1:0]         idx_i,
  input  logic [BUS_W-1:0]      dat_i,
  output logic [DATA_WIDTH-1:0] line_o
);
  logic [DATA_WIDTH-1:0] line_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) line_q <= '0;
    else if (clr_i) line_q <= '0;
    else if (we_i) line_q[idx_i*BUS_W +: BUS_W] <= dat_i;
  end
  assign line_o = line_q;
endmodule

// File: rtl/cache_line_fill.sv
// cache_line_fill: Wishbone burst line-fill engine with early critical-word forward.
// Define CACHE_FILL_CWF_EN to fetch the requested word first and wrap within the line.
module cache_line_fill import cache_fill_pkg::*; #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDRESS_WIDTH = 7
) (
  input logic i_clk,
  input logic i_rst,
  cache_line_fill_if.master bus
);
  localparam int WORDS = words_of(DATA_WIDTH);
  localparam int OFS = ofs_of(DATA_WIDTH);
  localparam int WB = OFS - 2;
  state_e state_q, state_d;
  logic [31-OFS:0] base_q;
  logic [WB-1:0] req_w_q, word_q, beat_q, first_w;
  logic [31:0] crit_q;
  logic crit_v_q, err_q, start, take, fail, last;
  logic [DATA_WIDTH-1:0] line;
  assign start = state_q == IDLE && bus.i_fill_req;
  assign fail = state_q == FETCH && bus.i_wb_err;
  assign take = state_q == FETCH && bus.i_wb_ack && !bus.i_wb_err;
  assign last = beat_q == WB'(WORDS - 1);
`ifdef CACHE_FILL_CWF_EN
  assign first_w = bus.i_fill_addr[OFS-1:2];
`else
  assign first_w = '0;
`endif
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE  ? (start ? FETCH : IDLE) :
              state_q == FETCH ? (fail ? IDLE : (take && last) ? WRITE : FETCH) : IDLE;
  end
  always_comb begin
    bus.o_fill_busy = state_q != IDLE;
    bus.o_wb_cyc = state_q == FETCH;
    bus.o_wb_stb = state_q == FETCH;
    bus.o_wb_sel = state_q == FETCH ? 4'hF : 4'h0;
    bus.o_wb_adr = state_q == FETCH ? {base_q, word_q, 2'b00} : '0;
    bus.o_fill_done = state_q == WRITE;
    bus.o_ram_write_enable = state_q == WRITE;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      base_q <= '0;
      req_w_q <= '0;
      word_q <= '0;
      beat_q <= '0;
      crit_q <= '0;
      crit_v_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      crit_v_q <= take && word_q == req_w_q;
      err_q <= fail;
      if (start) begin
        base_q <= bus.i_fill_addr[31:OFS];
        req_w_q <= bus.i_fill_addr[OFS-1:2];
        word_q <= first_w;
        beat_q <= '0;
      end else if (take) begin
        word_q <= word_q + WB'(1);
        beat_q <= beat_q + WB'(1);
        if (word_q == req_w_q) crit_q <= bus.i_wb_dat;
      end
    end
  end
  cache_line_assembler #(.DATA_WIDTH(DATA_WIDTH), .IW(WB)) u_asm (
    .clk(i_clk),
    .rst(i_rst),
    .clr_i(start),
    .we_i(take),
    .idx_i(word_q),
    .dat_i(bus.i_wb_dat),
    .line_o(line)
  );
  assign bus.o_fill_err = err_q;
  assign bus.o_crit_valid = crit_v_q;
  assign bus.o_crit_data = crit_q;
  assign bus.o_ram_address = base_q[ADDRESS_WIDTH-1:0];
  assign bus.o_ram_write_data = line;
endmodule

// File: doc/cache_line_fill.md
# cache_line_fill

Cache line-fill engine sitting directly upstream of the cache line RAM. On a miss it fetches one full line from the system bus as a burst of 32-bit Wishbone reads, assembles the beats into a DATA_WIDTH-bit line, and writes the line into the line RAM in a single write cycle. It also forwards the requested word early so the core can restart before the fill completes.

## Interface
- DATA_WIDTH, 128, line width in bits; must be a multiple of 32; WORDS = DATA_WIDTH/32.
- ADDRESS_WIDTH, 7, line-RAM index width; the number of lines is 2**ADDRESS_WIDTH.
- i_clk  in  1  sole clock; all logic is rising-edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_fill_req  in  1  level request; sampled only in IDLE.
- i_fill_addr  in  32  byte address of the missing word.
- o_fill_busy  out  1  high whenever the state is not IDLE.
- o_fill_done  out  1  one-cycle pulse when the line is written.
- o_fill_err  out  1  one-cycle pulse when the fill is aborted on a bus error.
- o_crit_valid  out  1  one-cycle pulse when the requested word is received.
- o_crit_data  out  32  the requested word; valid while o_crit_valid is high.
- o_wb_adr  out  32  bus word address (bits [1:0] = 0).
- o_wb_cyc, o_wb_stb  out  1 each  bus cycle and strobe.
- o_wb_sel  out  4  byte selects; 4'hF during a fill.
- i_wb_dat  in  32  read data.
- i_wb_ack, i_wb_err  in  1 each  beat acknowledge and beat error.
- o_ram_address  out  ADDRESS_WIDTH  line index = i_fill_addr[OFS +: ADDRESS_WIDTH], where OFS = log2(DATA_WIDTH/8).
- o_ram_write_data  out  DATA_WIDTH  assembled line; word w occupies bits [32w+31:32w].
- o_ram_write_enable  out  1  single-cycle line write.

## Operation
- States:
  - IDLE -> FETCH when i_fill_req is high. On this transition, latch the address and set start word S = i_fill_addr[OFS-1:2].
  - FETCH -> WRITE on the ack of the final beat.
  - FETCH -> IDLE on i_wb_err.
  - WRITE -> IDLE unconditionally.
- FETCH:
  - o_wb_cyc, o_wb_stb and o_wb_sel = 4'hF are held for the whole burst.
  - o_wb_adr = {line base, beat word, 2'b00}.
  - The beat word is the start word plus the beat count, modulo WORDS (wrap-around within the line).
  - Each sampled i_wb_ack stores i_wb_dat into the lane for the current word, advances the word, and increments the beat count.
- Critical word:
  - On the ack of word S, o_crit_data is registered from i_wb_dat and o_crit_valid pulses.
  - This happens exactly once per fill.
- WRITE:
  - o_ram_write_enable = 1 and o_fill_done = 1 for exactly one cycle.
  - o_ram_address and o_ram_write_data are stable during that cycle.
- Error:
  - i_wb_err on any beat drops cyc/stb on the next cycle and pulses o_fill_err.
  - No RAM write occurs; the partial line is discarded.
  - If word S has already been forwarded, that forward stands.
- i_fill_req while busy is ignored. The requester holds the request, or re-raises it after o_fill_busy falls.
- i_wb_ack outside FETCH is ignored.
- If i_wb_ack and i_wb_err are high together, the error wins.

## Timing
- Reset: the state is IDLE and every output is 0, including o_wb_adr, o_ram_address, o_ram_write_data and o_crit_data.
- Reset mid-fill: the bus cycle is dropped asynchronously, nothing is written, and no done or err pulse is produced.
- All outputs are registered.
- With a request sampled at edge 0 and zero-wait acks:
  - cyc is high in cycles 1..WORDS;
  - the write occurs in cycle WORDS+1;
  - o_fill_busy is low from cycle WORDS+2, and a new request is accepted at the edge ending that cycle.
- Wait states extend FETCH by one cycle per non-acked cycle; o_wb_adr is held during waits.
- o_crit_valid is asserted in the cycle after the edge that samples the ack for word S.

## Configuration
- CACHE_FILL_CWF_EN: critical-word-first.
- Defined: the burst starts at word S and wraps, so o_crit_valid arrives one cycle after the first ack.
- Undefined: S for address ordering is forced to 0, so the burst always runs words 0..WORDS-1. o_crit_valid still pulses on the ack of the requested word, which arrives (S+1) ack-cycles into the burst.
- Line contents and the RAM write are identical in both modes.

## Structure
- The shared package cache_fill_pkg holds:
  - the state enum (IDLE, FETCH, WRITE);
  - the bus width constant 32;
  - the WORDS/OFS derivation functions.
- Sub-module cache_line_assembler: the lane-addressed beat register that turns word index + data + strobe into a DATA_WIDTH line, with a clear on fill start.

## Test plan
- Miss at 0x0000_1238 with zero-wait acks, CWF on:
  - bus addresses are 0x1238, 0x123C, 0x1230, 0x1234;
  - o_crit_data is the first beat;
  - RAM index 0x23 is written with lanes {w3,w2,w1,w0} placed correctly.
- Same miss with CWF off:
  - addresses are 0x1230..0x123C;
  - o_crit_valid follows the 3rd ack;
  - the line is identical.
- Two wait cycles before each ack:
  - o_wb_adr is held while waiting;
  - the write occurs in cycle 13;
  - done pulses once.
- i_wb_err on the 2nd beat:
  - cyc drops the next cycle;
  - o_fill_err pulses;
  - o_ram_write_enable is never asserted;
  - o_fill_busy is low the following cycle.
- i_rst asserted after the 2nd ack:
  - all outputs go to 0 immediately;
  - no write occurs;
  - the next request fetches a full line.
- i_fill_req held high continuously across two fills:
  - the second request is accepted only after o_fill_busy falls;
  - no extra write occurs.
